interrupt_arbiter: RTL and testbench

Shares the single interrupt command engine among `N_REQ` independent requesters, such as action kernels or DMA engines. Each requester raises a level-held interrupt request carrying a 64-bit source address and a context ID. The arbiter selects one requester round-robin, presents its request to the engine through the engine's four-phase req/ack handshake, and returns the ack to the winning requester. It sits between the action/AXI side and the TLX interrupt engine in the opencapi30 infrastructure.

---
 rtl/ocaccel_intr_pkg.sv | 25 ++
 rtl/rr_arbiter_core.sv | 30 +++
 rtl/interrupt_arbiter.sv | 110 +++++++++++
 tb/tb_interrupt_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocaccel_intr_pkg.sv
// Shared definitions for the interrupt infrastructure: FSM encodings, the
// source-address width and a constant-foldable clog2 helper.
package ocaccel_intr_pkg;

    localparam int unsigned INTR_SRC_W = 64;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StIssue = 3'b010,
        StDone  = 3'b100
    } intr_state_e;

    // Never returns less than 1 so a 1-bit index still has a legal width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first set candidate above last_grant,
// wrapping modulo N_REQ. valid is low only when no candidate is set.
module rr_arbiter_core
    import ocaccel_intr_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        cand,
    input  logic [clog2(N_REQ)-1:0] last_grant,
    output logic [clog2(N_REQ)-1:0] grant,
    output logic                    valid
);

    localparam int unsigned IDW = clog2(N_REQ);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = (32'(last_grant) + off) % N_REQ;
            if (!valid && cand[idx]) begin
                valid = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Shares one four-phase interrupt engine among N_REQ requesters, granting
// round-robin and returning the engine ack to the winner.
module interrupt_arbiter
    import ocaccel_intr_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CTXW  = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_enable,
    input  logic [N_REQ-1:0]            up_req,
    input  logic [N_REQ*INTR_SRC_W-1:0] up_src,
    input  logic [N_REQ*CTXW-1:0]       up_ctx,
    output logic [N_REQ-1:0]            up_ack,
    output logic                        interrupt_req,
    output logic [INTR_SRC_W-1:0]       interrupt_src,
    output logic [CTXW-1:0]             interrupt_ctx,
    input  logic                        interrupt_ack,
    output logic                        busy,
    output logic [clog2(N_REQ)-1:0]     grant_id,
    output logic [31:0]                 served_cnt
);

    localparam int unsigned IDW = clog2(N_REQ);

    intr_state_e           state_q, state_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [INTR_SRC_W-1:0] src_q, src_d;
    logic [CTXW-1:0]       ctx_q, ctx_d;
    logic [31:0]           served_q, served_d;

    logic [IDW-1:0]        win_idx;
    logic                  win_valid;

    rr_arbiter_core #(
        .N_REQ (N_REQ)
    ) u_rr (
        .cand       (up_req & req_enable),
        .last_grant (last_grant_q),
        .grant      (win_idx),
        .valid      (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IDW'(N_REQ - 1);
            grant_q      <= '0;
            src_q        <= '0;
            ctx_q        <= '0;
            served_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            src_q        <= src_d;
            ctx_q        <= ctx_d;
            served_q     <= served_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        src_d        = src_q;
        ctx_d        = ctx_q;
        served_d     = served_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d      = StIssue;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    src_d        = up_src[32'(win_idx) * INTR_SRC_W +: INTR_SRC_W];
                    ctx_d        = up_ctx[32'(win_idx) * CTXW +: CTXW];
                end
            end
            StIssue: begin
                // Failed and successful interrupts ack identically; both are counted.
                if (interrupt_ack) begin
                    state_d  = StDone;
                    served_d = served_q + 32'd1;
                end
            end
            StDone: begin
                if (!up_req[grant_q] && !interrupt_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        up_ack        = '0;
        interrupt_req = (state_q == StIssue);
        busy          = (state_q != StIdle);
        if (state_q == StDone) begin
            up_ack[grant_q] = 1'b1;
        end
        interrupt_src = src_q;
        interrupt_ctx = ctx_q;
        grant_id      = grant_q;
        served_cnt    = served_q;
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter with a behavioural engine and requesters.
module tb_interrupt_arbiter;

    localparam int N  = 4;
    localparam int CW = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_enable;
    logic [N-1:0]      up_req;
    logic [N*64-1:0]   up_src;
    logic [N*CW-1:0]   up_ctx;
    logic [N-1:0]      up_ack;
    logic              interrupt_req;
    logic [63:0]       interrupt_src;
    logic [CW-1:0]     interrupt_ctx;
    logic              interrupt_ack;
    logic              busy;
    logic [1:0]        grant_id;
    logic [31:0]       served_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]    id;
        logic [63:0]   src;
        logic [CW-1:0] ctx;
    } exp_t;

    typedef struct {
        bit            ok;
        int            lat;
        logic [1:0]    id;
        logic [63:0]   src;
        logic [CW-1:0] ctx;
        logic [N-1:0]  ack;
        logic          req_after;
        int            done_cyc;
        bit            idle;
    } obs_t;

    exp_t sb[$];

    interrupt_arbiter #(
        .N_REQ (N),
        .CTXW  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_enable    (req_enable),
        .up_req        (up_req),
        .up_src        (up_src),
        .up_ctx        (up_ctx),
        .up_ack        (up_ack),
        .interrupt_req (interrupt_req),
        .interrupt_src (interrupt_src),
        .interrupt_ctx (interrupt_ctx),
        .interrupt_ack (interrupt_ack),
        .busy          (busy),
        .grant_id      (grant_id),
        .served_cnt    (served_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] src_of(input int i);
        return 64'hA5A5_0000_0000_1000 + 64'(i) * 64'h100;
    endfunction

    function automatic logic [CW-1:0] ctx_of(input int i);
        return CW'(i * 3 + 7);
    endfunction

    task automatic load_sources();
        for (int i = 0; i < N; i++) begin
            up_src[i*64 +: 64] = src_of(i);
            up_ctx[i*CW +: CW] = ctx_of(i);
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        req_enable    = '1;
        up_req        = '0;
        interrupt_ack = 1'b0;
        load_sources();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Engine + winning requester: ack after the request shows, then drop the
    // ack and the requester's level after the given holds, counting DONE cycles.
    task automatic run_txn(input int ack_hold, input int req_hold, input bit rereq,
                           output obs_t o);
        int g;
        o.ok = 0; o.lat = 0; o.id = '0; o.src = '0; o.ctx = '0;
        o.ack = '0; o.req_after = 1'b0; o.done_cyc = 0; o.idle = 0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk);
            if (interrupt_req === 1'b1) begin
                o.ok  = 1;
                o.lat = w;
                break;
            end
        end
        if (!o.ok) return;
        o.id  = grant_id;
        o.src = interrupt_src;
        o.ctx = interrupt_ctx;
        g     = int'(grant_id);
        interrupt_ack = 1'b1;
        @(negedge clk);
        o.ack       = up_ack;
        o.req_after = interrupt_req;
        for (int c = 0; c < 40; c++) begin
            if (up_ack === '0) break;
            o.done_cyc++;
            if (c >= req_hold) up_req[g] = 1'b0;
            if (c >= ack_hold) interrupt_ack = 1'b0;
            @(negedge clk);
        end
        o.idle        = (busy === 1'b0);
        interrupt_ack = 1'b0;
        if (rereq) up_req[g] = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({interrupt_req, busy, up_ack} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b busy=%b ack=%b expected all 0",
                     interrupt_req, busy, up_ack);
        end
        checks++;
        if ({interrupt_src, interrupt_ctx} !== '0) begin
            failures++;
            $display("FAIL reset_data: got src=%h ctx=%h expected 0", interrupt_src, interrupt_ctx);
        end
        checks++;
        if (grant_id !== 2'd0 || served_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got grant=%0d served=%0d expected 0 0", grant_id, served_cnt);
        end
    endtask

    task automatic test_single();
        obs_t o;
        exp_t e;
        apply_reset();
        up_src[2*64 +: 64] = 64'h0000_0000_DEAD_B000;
        up_ctx[2*CW +: CW] = CW'(9'h1A);
        sb.push_back('{id: 2'd2, src: 64'h0000_0000_DEAD_B000, ctx: CW'(9'h1A)});
        up_req = 4'b0100;
        run_txn(0, 0, 1'b0, o);
        e = sb.pop_front();
        checks++;
        if (!o.ok || o.lat != 1) begin
            failures++;
            $display("FAIL single_latency: got ok=%0d lat=%0d expected ok=1 lat=1", o.ok, o.lat);
        end
        checks++;
        if (o.src !== e.src || o.ctx !== e.ctx) begin
            failures++;
            $display("FAIL single_payload: got src=%h ctx=%h expected src=%h ctx=%h",
                     o.src, o.ctx, e.src, e.ctx);
        end
        checks++;
        if (o.ack !== 4'b0100 || o.req_after !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: got up_ack=%b req=%b expected 0100 0", o.ack, o.req_after);
        end
        checks++;
        if (served_cnt !== 32'd1 || grant_id !== e.id) begin
            failures++;
            $display("FAIL single_count: got served=%0d grant=%0d expected 1 %0d",
                     served_cnt, grant_id, e.id);
        end
        checks++;
        if (o.done_cyc != 1 || !o.idle) begin
            failures++;
            $display("FAIL single_exit: got done_cyc=%0d idle=%0d expected 1 1", o.done_cyc, o.idle);
        end
    endtask

    task automatic test_round_robin(input logic [N-1:0] en, input string name);
        obs_t o;
        exp_t e;
        int   n;
        int   k;
        apply_reset();
        req_enable = en;
        n = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    sb.push_back('{id: 2'(i), src: src_of(i), ctx: ctx_of(i)});
                    n++;
                end
            end
        end
        k = n;
        up_req = '1;
        for (int t = 0; t < k; t++) begin
            run_txn(0, 0, 1'b1, o);
            e = sb.pop_front();
            checks++;
            if (!o.ok || o.id !== e.id || o.src !== e.src || o.ctx !== e.ctx) begin
                failures++;
                $display("FAIL %s_grant%0d: got ok=%0d id=%0d src=%h expected id=%0d src=%h",
                         name, t, o.ok, o.id, o.src, e.id, e.src);
            end
            checks++;
            if (o.ack !== (4'b0001 << e.id)) begin
                failures++;
                $display("FAIL %s_ack%0d: got up_ack=%b expected %b",
                         name, t, o.ack, 4'b0001 << e.id);
            end
        end
        checks++;
        if (served_cnt !== 32'(k)) begin
            failures++;
            $display("FAIL %s_served: got %0d expected %0d", name, served_cnt, k);
        end
    endtask

    task automatic test_exit_order();
        obs_t o;
        exp_t e;
        int   ah[3] = '{5, 0, 0};
        int   rh[3] = '{0, 5, 0};
        apply_reset();
        for (int t = 0; t < 3; t++) begin
            sb.push_back('{id: 2'd1, src: src_of(1), ctx: ctx_of(1)});
            up_req = 4'b0010;
            run_txn(ah[t], rh[t], 1'b0, o);
            e = sb.pop_front();
            checks++;
            if (!o.ok || o.id !== e.id || o.done_cyc != ((ah[t] > rh[t]) ? ah[t] : rh[t]) + 1
                || !o.idle) begin
                failures++;
                $display("FAIL exit_order%0d: got ok=%0d id=%0d done_cyc=%0d idle=%0d expected id=%0d done_cyc=%0d idle=1",
                         t, o.ok, o.id, o.done_cyc, o.idle, e.id,
                         ((ah[t] > rh[t]) ? ah[t] : rh[t]) + 1);
            end
        end
    endtask

    task automatic test_src_change();
        obs_t o;
        exp_t e;
        bit   seen;
        apply_reset();
        sb.push_back('{id: 2'd3, src: src_of(3), ctx: ctx_of(3)});
        up_req = 4'b1000;
        seen = 0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            seen = (interrupt_req === 1'b1);
        end
        up_src[3*64 +: 64] = 64'hFFFF_EEEE_DDDD_CCCC;
        up_ctx[3*CW +: CW] = CW'(9'h155);
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (!seen || interrupt_src !== e.src || interrupt_ctx !== e.ctx) begin
            failures++;
            $display("FAIL src_hold: got seen=%0d src=%h ctx=%h expected src=%h ctx=%h",
                     seen, interrupt_src, interrupt_ctx, e.src, e.ctx);
        end
        run_txn(0, 0, 1'b0, o);
        checks++;
        if (!o.ok || o.src !== e.src || o.ack !== 4'b1000) begin
            failures++;
            $display("FAIL src_done: got ok=%0d src=%h ack=%b expected src=%h ack=1000",
                     o.ok, o.src, o.ack, e.src);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        bit   seen;
        apply_reset();
        up_req = '1;
        repeat (2) begin
            run_txn(0, 0, 1'b1, o);
        end
        seen = 0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            seen = (interrupt_req === 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || {interrupt_req, busy, up_ack, interrupt_src, interrupt_ctx} !== '0
            || grant_id !== 2'd0 || served_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: got seen=%0d req=%b busy=%b ack=%b src=%h grant=%0d served=%0d expected all 0",
                     seen, interrupt_req, busy, up_ack, interrupt_src, grant_id, served_cnt);
        end
        rst = 1'b0;
        sb.push_back('{id: 2'd0, src: src_of(0), ctx: ctx_of(0)});
        run_txn(0, 0, 1'b1, o);
        e = sb.pop_front();
        checks++;
        if (!o.ok || o.lat != 1 || o.id !== e.id || o.src !== e.src) begin
            failures++;
            $display("FAIL reset_first_grant: got ok=%0d lat=%0d id=%0d src=%h expected lat=1 id=%0d src=%h",
                     o.ok, o.lat, o.id, o.src, e.id, e.src);
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_enable    = '0;
        up_req        = '0;
        up_src        = '0;
        up_ctx        = '0;
        interrupt_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin(4'b1111, "all");
        test_round_robin(4'b1010, "masked");
        test_exit_order();
        test_src_change();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
